// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART echo engine.
package uart_pkg;

    localparam logic [1:0] MODE_ECHO = 2'd0;
    localparam logic [1:0] MODE_CRLF = 2'd1;
    localparam logic [1:0] MODE_HOLD = 2'd2;

    localparam int         OVERSAMPLE = 16;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

    // Serial framer state, shared by the receiver and transmitter.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    // Map the reserved mode encoding onto plain echo.
    function automatic logic [1:0] eff_mode(input logic [1:0] m);
        logic [1:0] r;
        case (m)
            MODE_ECHO: r = MODE_ECHO;
            MODE_CRLF: r = MODE_CRLF;
            MODE_HOLD: r = MODE_HOLD;
            default:   r = MODE_ECHO;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// Byte FIFO between the receiver and transmitter, with registered flags.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic             clk,
    input  logic             key_reset,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q,  count_d;
    logic             full_q,   full_d;
    logic             empty_q,  empty_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Accept/advance decisions; a full FIFO still accepts if a pop frees a slot.
    always_comb begin
        pop_ok_s  = pop & ~empty_q;
        push_ok_s = push & (~full_q | pop_ok_s);
        wr_ptr_d  = push_ok_s ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d  = pop_ok_s  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
        full_d  = (count_d == (AW+1)'(DEPTH));
        empty_d = (count_d == '0);
    end

    // Pointer, occupancy and flag registers.
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
        end
    end

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_q[wr_ptr_q] <= din;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign full  = full_q;
    assign empty = empty_q;

endmodule

// File: rtl/uart_echo_server.sv
// UART echo engine: oversampled receiver, FIFO buffer, transmitter with CR->CRLF option.
module uart_echo_server
    import uart_pkg::*;
#(
    parameter int DIVISOR   = 27,
    parameter int DATA_BITS = 8,
    parameter int DEPTH     = 16,
    parameter int ERR_W     = 8
) (
    input  logic             clk,
    input  logic             key_reset,
    input  logic             rx,
    input  logic [1:0]       mode,
    input  logic             clr_err,
    output logic             tx,
    output logic             ntx_full,
    output logic             nrx_empty,
    output logic             overrun,
    output logic [ERR_W-1:0] frame_err_cnt
);

    localparam int             CNT_W     = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(DIVISOR - 1);
    localparam logic [3:0]     TICK_LAST = 4'(OVERSAMPLE - 1);
    localparam logic [3:0]     TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0]     BIT_LAST  = 4'(DATA_BITS - 1);
    localparam logic [DATA_BITS-1:0] CR_CHAR = ASCII_CR[DATA_BITS-1:0];
    localparam logic [DATA_BITS-1:0] LF_CHAR = ASCII_LF[DATA_BITS-1:0];

    // Tick generator and input synchronizer
    logic [CNT_W-1:0] div_q, div_d;
    logic             tick_s;
    logic [1:0]       sync_q, sync_d;
    logic             rx_s;

    // Receiver
    uart_state_e          rx_state_q, rx_state_d;
    logic [3:0]           rx_tick_q,  rx_tick_d;
    logic [3:0]           rx_bit_q,   rx_bit_d;
    logic [DATA_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                 rx_valid_s;
    logic                 frame_err_s;

    // Transmitter
    uart_state_e          tx_state_q, tx_state_d;
    logic [3:0]           tx_tick_q,  tx_tick_d;
    logic [3:0]           tx_bit_q,   tx_bit_d;
    logic [DATA_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                 armed_q,    armed_d;
    logic                 lf_pend_q,  lf_pend_d;
    logic                 tx_q,       tx_d;
    logic [1:0]           mode_s;
    logic                 pop_s;

    // FIFO and status
    logic                 fifo_full_s, fifo_empty_s;
    logic [DATA_BITS-1:0] fifo_dout_s;
    logic                 overrun_q, overrun_d;
    logic [ERR_W-1:0]     err_cnt_q, err_cnt_d;

    // Free-running oversample tick and two-stage rx synchronizer.
    always_comb begin
        tick_s = (div_q == DIV_LAST);
        if (tick_s) begin
            div_d = '0;
        end else begin
            div_d = div_q + CNT_W'(1);
        end
        sync_d = {sync_q[0], rx};
        rx_s   = sync_q[1];
    end

    // Receiver next state: start qualification, mid-bit data and stop sampling.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_tick_d  = rx_tick_q;
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    rx_state_d = ST_START;
                    rx_tick_d  = 4'd0;
                end else begin
                    rx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && rx_tick_q == TICK_MID) begin
                    rx_tick_d  = 4'd0;
                    rx_bit_d   = 4'd0;
                    rx_state_d = rx_s ? ST_IDLE : ST_DATA;
                end else if (tick_s) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                end else begin
                    rx_tick_d = rx_tick_q;
                end
            end
            ST_DATA: begin
                if (tick_s && rx_tick_q == TICK_LAST) begin
                    rx_tick_d  = 4'd0;
                    rx_shift_d = {rx_s, rx_shift_q[DATA_BITS-1:1]};
                    if (rx_bit_q == BIT_LAST) begin
                        rx_state_d = ST_STOP;
                    end else begin
                        rx_bit_d = rx_bit_q + 4'd1;
                    end
                end else if (tick_s) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                end else begin
                    rx_tick_d = rx_tick_q;
                end
            end
            ST_STOP: begin
                if (tick_s && rx_tick_q == TICK_LAST) begin
                    rx_tick_d  = 4'd0;
                    rx_state_d = ST_IDLE;
                end else if (tick_s) begin
                    rx_tick_d = rx_tick_q + 4'd1;
                end else begin
                    rx_tick_d = rx_tick_q;
                end
            end
            default: rx_state_d = ST_IDLE;
        endcase
    end

    // Receiver outputs: one-clock byte-complete or framing-error strobe at stop mid-bit.
    always_comb begin
        rx_valid_s  = 1'b0;
        frame_err_s = 1'b0;
        if (rx_state_q == ST_STOP && tick_s && rx_tick_q == TICK_LAST) begin
            rx_valid_s  = rx_s;
            frame_err_s = ~rx_s;
        end else begin
            rx_valid_s  = 1'b0;
            frame_err_s = 1'b0;
        end
    end

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .key_reset (key_reset),
        .push      (rx_valid_s),
        .din       (rx_shift_q),
        .pop       (pop_s),
        .dout      (fifo_dout_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // Transmitter outputs: pop a byte only when idle with nothing staged or pending.
    always_comb begin
        mode_s = eff_mode(mode);
        if (tx_state_q == ST_IDLE && !armed_q && !lf_pend_q && !fifo_empty_s
            && mode_s != MODE_HOLD) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Transmitter next state: stage a byte, align to tick, shift out 16 ticks per bit.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_tick_d  = tx_tick_q;
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        armed_d    = armed_q;
        lf_pend_d  = lf_pend_q;
        case (tx_state_q)
            ST_IDLE: begin
                if (armed_q && tick_s) begin
                    tx_state_d = ST_START;
                    tx_tick_d  = 4'd0;
                    armed_d    = 1'b0;
                end else if (armed_q) begin
                    armed_d = 1'b1;
                end else if (lf_pend_q) begin
                    tx_shift_d = LF_CHAR;
                    lf_pend_d  = 1'b0;
                    armed_d    = 1'b1;
                end else if (pop_s) begin
                    tx_shift_d = fifo_dout_s;
                    lf_pend_d  = (mode_s == MODE_CRLF) && (fifo_dout_s == CR_CHAR);
                    armed_d    = 1'b1;
                end else begin
                    tx_state_d = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && tx_tick_q == TICK_LAST) begin
                    tx_state_d = ST_DATA;
                    tx_tick_d  = 4'd0;
                    tx_bit_d   = 4'd0;
                end else if (tick_s) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                end else begin
                    tx_tick_d = tx_tick_q;
                end
            end
            ST_DATA: begin
                if (tick_s && tx_tick_q == TICK_LAST) begin
                    tx_tick_d  = 4'd0;
                    tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                    if (tx_bit_q == BIT_LAST) begin
                        tx_state_d = ST_STOP;
                    end else begin
                        tx_bit_d = tx_bit_q + 4'd1;
                    end
                end else if (tick_s) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                end else begin
                    tx_tick_d = tx_tick_q;
                end
            end
            ST_STOP: begin
                if (tick_s && tx_tick_q == TICK_LAST) begin
                    tx_tick_d  = 4'd0;
                    tx_state_d = ST_IDLE;
                end else if (tick_s) begin
                    tx_tick_d = tx_tick_q + 4'd1;
                end else begin
                    tx_tick_d = tx_tick_q;
                end
            end
            default: tx_state_d = ST_IDLE;
        endcase
        // Line level follows the next state so tx is a clean registered output.
        case (tx_state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = tx_shift_d[0];
            default:  tx_d = 1'b1;
        endcase
    end

    // Sticky overrun and saturating framing-error count; clear wins over set.
    always_comb begin
        if (clr_err) begin
            overrun_d = 1'b0;
        end else if (rx_valid_s && fifo_full_s && !pop_s) begin
            overrun_d = 1'b1;
        end else begin
            overrun_d = overrun_q;
        end
        if (clr_err) begin
            err_cnt_d = '0;
        end else if (frame_err_s && err_cnt_q != {ERR_W{1'b1}}) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
        end else begin
            err_cnt_d = err_cnt_q;
        end
    end

    // Tick, synchronizer and receiver state registers.
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            div_q      <= '0;
            sync_q     <= 2'b11;
            rx_state_q <= ST_IDLE;
            rx_tick_q  <= 4'd0;
            rx_bit_q   <= 4'd0;
            rx_shift_q <= '0;
        end else begin
            div_q      <= div_d;
            sync_q     <= sync_d;
            rx_state_q <= rx_state_d;
            rx_tick_q  <= rx_tick_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
        end
    end

    // Transmitter state registers and the tx line flop.
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            tx_state_q <= ST_IDLE;
            tx_tick_q  <= 4'd0;
            tx_bit_q   <= 4'd0;
            tx_shift_q <= '0;
            armed_q    <= 1'b0;
            lf_pend_q  <= 1'b0;
            tx_q       <= 1'b1;
        end else begin
            tx_state_q <= tx_state_d;
            tx_tick_q  <= tx_tick_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
            armed_q    <= armed_d;
            lf_pend_q  <= lf_pend_d;
            tx_q       <= tx_d;
        end
    end

    // Error status registers.
    always_ff @(posedge clk or negedge key_reset) begin
        if (!key_reset) begin
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign tx            = tx_q;
    assign ntx_full      = ~fifo_full_s;
    assign nrx_empty     = ~fifo_empty_s;
    assign overrun       = overrun_q;
    assign frame_err_cnt = err_cnt_q;

endmodule

// File: tb/tb_uart_echo_server.sv
// Directed bench for uart_echo_server with a TX-frame scoreboard (16 clk per bit).
module tb_uart_echo_server;

    logic       clk;
    logic       key_reset;
    logic       rx;
    logic [1:0] mode;
    logic       clr_err;
    logic       tx;
    logic       ntx_full;
    logic       nrx_empty;
    logic       overrun;
    logic [1:0] frame_err_cnt;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb[$];
    bit         mon_busy = 1'b0;
    bit         mon_abort = 1'b0;
    bit         saw_nonempty = 1'b0;
    int         tx_falls = 0;

    uart_echo_server #(
        .DIVISOR   (1),
        .DATA_BITS (8),
        .DEPTH     (16),
        .ERR_W     (2)
    ) dut (
        .clk           (clk),
        .key_reset     (key_reset),
        .rx            (rx),
        .mode          (mode),
        .clr_err       (clr_err),
        .tx            (tx),
        .ntx_full      (ntx_full),
        .nrx_empty     (nrx_empty),
        .overrun       (overrun),
        .frame_err_cnt (frame_err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Serial driver; a bad frame holds the stop bit low past its mid-point.
    task automatic send_byte(input logic [7:0] b, input bit bad);
        rx = 1'b0;
        repeat (16) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (16) @(negedge clk);
        end
        if (bad) begin
            rx = 1'b0;
            repeat (12) @(negedge clk);
            rx = 1'b1;
            repeat (24) @(negedge clk);
        end else begin
            rx = 1'b1;
            repeat (16) @(negedge clk);
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while ((sb.size() != 0 || mon_busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        check(tag, {31'd0, (sb.size() == 0 && !mon_busy)}, 32'd1);
        repeat (20) @(negedge clk);
    endtask

    // Count start-bit edges on the line.
    initial forever begin
        @(negedge tx);
        tx_falls++;
    end

    // Latch any cycle where the FIFO reports data.
    always @(negedge clk) begin
        if (nrx_empty === 1'b1) saw_nonempty = 1'b1;
    end

    // TX monitor: decode each frame at mid-bit and compare with the scoreboard.
    initial forever begin
        logic       sbit;
        logic       pbit;
        logic [7:0] d;
        logic [7:0] exp;
        @(negedge tx);
        mon_busy = 1'b1;
        repeat (8) @(negedge clk);
        sbit = tx;
        for (int i = 0; i < 8; i++) begin
            repeat (16) @(negedge clk);
            d[i] = tx;
        end
        repeat (16) @(negedge clk);
        pbit = tx;
        if (mon_abort) begin
            mon_abort = 1'b0;
        end else if (sb.size() == 0) begin
            check("unexpected_tx_frame", {24'd0, d}, 32'hFFFF_FFFF);
        end else begin
            exp = sb.pop_front();
            check("tx_start_bit", {31'd0, sbit}, 32'd0);
            check("tx_data", {24'd0, d}, {24'd0, exp});
            check("tx_stop_bit", {31'd0, pbit}, 32'd1);
        end
        mon_busy = 1'b0;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int falls0;
        key_reset = 1'b0;
        rx        = 1'b1;
        mode      = 2'd0;
        clr_err   = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx", {31'd0, tx}, 32'd1);
        check("rst_ntx_full", {31'd0, ntx_full}, 32'd1);
        check("rst_nrx_empty", {31'd0, nrx_empty}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_err_cnt", {30'd0, frame_err_cnt}, 32'd0);
        key_reset = 1'b1;
        repeat (5) @(negedge clk);

        // Plain echo of 0x55.
        mode = 2'd0;
        saw_nonempty = 1'b0;
        sb.push_back(8'h55);
        send_byte(8'h55, 1'b0);
        wait_drain("drain_55");
        check("echo_err_cnt", {30'd0, frame_err_cnt}, 32'd0);
        check("echo_nonempty_pulse", {31'd0, saw_nonempty}, 32'd1);
        check("echo_nrx_empty_after", {31'd0, nrx_empty}, 32'd0);

        // CR->CRLF expansion.
        mode = 2'd1;
        sb.push_back(8'h41);
        sb.push_back(8'h0D);
        sb.push_back(8'h0A);
        sb.push_back(8'h42);
        send_byte(8'h41, 1'b0);
        send_byte(8'h0D, 1'b0);
        send_byte(8'h42, 1'b0);
        wait_drain("drain_crlf");

        // Hold mode: fill the FIFO and overflow by one.
        mode = 2'd2;
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i), 1'b0);
        end
        check("hold_ntx_full_16", {31'd0, ntx_full}, 32'd0);
        check("hold_overrun_16", {31'd0, overrun}, 32'd0);
        check("hold_no_tx", {31'd0, mon_busy}, 32'd0);
        send_byte(8'h10, 1'b0);
        check("hold_overrun_17", {31'd0, overrun}, 32'd1);
        for (int i = 0; i < 16; i++) begin
            sb.push_back(8'(i));
        end
        mode = 2'd0;
        wait_drain("drain_hold");
        repeat (200) @(negedge clk);
        check("hold_drained_empty", {31'd0, nrx_empty}, 32'd0);
        check("hold_drained_ntx_full", {31'd0, ntx_full}, 32'd1);

        // Framing error, then clear.
        falls0 = tx_falls;
        send_byte(8'hA5, 1'b1);
        repeat (40) @(negedge clk);
        check("bad_no_tx", tx_falls - falls0, 32'd0);
        check("bad_err_cnt_1", {30'd0, frame_err_cnt}, 32'd1);
        check("bad_nrx_empty", {31'd0, nrx_empty}, 32'd0);
        check("pre_clr_overrun", {31'd0, overrun}, 32'd1);
        clr_err = 1'b1;
        @(negedge clk);
        clr_err = 1'b0;
        check("clr_err_cnt", {30'd0, frame_err_cnt}, 32'd0);
        check("clr_overrun", {31'd0, overrun}, 32'd0);

        // Saturation of the 2-bit counter.
        for (int i = 0; i < 3; i++) begin
            send_byte(8'hA5, 1'b1);
        end
        check("sat_err_cnt_3", {30'd0, frame_err_cnt}, 32'd3);
        send_byte(8'hA5, 1'b1);
        check("sat_err_cnt_4", {30'd0, frame_err_cnt}, 32'd3);

        // Reset in the middle of a transmitted data bit.
        sb.push_back(8'hF0);
        send_byte(8'hF0, 1'b0);
        repeat (24) @(negedge clk);
        check("pre_rst_tx_busy", {31'd0, mon_busy}, 32'd1);
        mon_abort = 1'b1;
        sb.delete();
        key_reset = 1'b0;
        #1;
        check("midrst_tx", {31'd0, tx}, 32'd1);
        check("midrst_nrx_empty", {31'd0, nrx_empty}, 32'd0);
        check("midrst_err_cnt", {30'd0, frame_err_cnt}, 32'd0);
        repeat (3) @(negedge clk);
        key_reset = 1'b1;
        repeat (200) @(negedge clk);
        check("post_rst_idle", {31'd0, tx}, 32'd1);
        sb.push_back(8'h3C);
        send_byte(8'h3C, 1'b0);
        wait_drain("drain_3c");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
